// File: rtl/mem2_pkg.sv
// mem2_pkg: shared types for the MEM2 pipeline stage.
// Load types, write-back selects, stage states and the held control bundle.
package mem2_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    WB_PC8  = 2'd0,
    WB_ALU  = 2'd1,
    WB_OUTB = 2'd2,
    WB_LOAD = 2'd3
  } wbsel_e;

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_WAIT_LOAD = 2'd1,
    S_FULL      = 2'd2
  } mem2_state_e;

  // Bundle fields are sized for the widest supported build.
  localparam int unsigned PC_W_MAX   = 64;
  localparam int unsigned REG_AW_MAX = 8;
  localparam int unsigned OFF_W_MAX  = 3;

  typedef struct packed {
    logic [PC_W_MAX-1:0]   pc;
    logic [REG_AW_MAX-1:0] dst;
    logic                  regs_wr;
    wbsel_e                wbsel;
    load_type_e            load_type;
    logic [OFF_W_MAX-1:0]  addr;
  } mem2_ctl_t;

  function automatic logic is_misaligned(
    input load_type_e lt,
    input logic [1:0] a
  );
    return (((lt == LH) || (lt == LHU)) && a[0])
        || ((lt == LW) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem2_stage_hs_if.sv
// mem2_stage_hs_if: MEM->MEM2->WB handshake, data-bus and forwarding bundle.
// slave = stage side, master = environment side. Adds out_addr_err with MEM2_ALIGN_CHECK_EN.
interface mem2_stage_hs_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned REG_AW = 5
);
  import mem2_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_alu_out;
  logic [DATA_W-1:0] in_outb;
  wbsel_e            in_wbsel;
  logic [REG_AW-1:0] in_dst;
  logic              in_regs_wr;
  load_type_e        in_load_type;
  logic [DATA_W-1:0] dbus_rdata;
  logic              dbus_data_ok;
  logic              out_valid;
  logic              wb_ready;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_result;
  logic [REG_AW-1:0] out_dst;
  logic              out_regs_wr;
  logic              fwd_valid;
  logic              fwd_data_ok;
  logic [DATA_W-1:0] fwd_result;
  logic [REG_AW-1:0] fwd_dst;
  logic              fwd_regs_wr;
  logic              stall_req;
`ifdef MEM2_ALIGN_CHECK_EN
  logic              out_addr_err;
`endif

  modport slave (
`ifdef MEM2_ALIGN_CHECK_EN
    output out_addr_err,
`endif
    input  flush, in_valid, in_pc, in_alu_out,
    input  in_outb, in_wbsel, in_dst,
    input  in_regs_wr, in_load_type,
    input  dbus_rdata, dbus_data_ok, wb_ready,
    output in_ready, out_valid, out_pc,
    output out_result, out_dst, out_regs_wr,
    output fwd_valid, fwd_data_ok, fwd_result,
    output fwd_dst, fwd_regs_wr, stall_req
  );

  modport master (
`ifdef MEM2_ALIGN_CHECK_EN
    input  out_addr_err,
`endif
    output flush, in_valid, in_pc, in_alu_out,
    output in_outb, in_wbsel, in_dst,
    output in_regs_wr, in_load_type,
    output dbus_rdata, dbus_data_ok, wb_ready,
    input  in_ready, out_valid, out_pc,
    input  out_result, out_dst, out_regs_wr,
    input  fwd_valid, fwd_data_ok, fwd_result,
    input  fwd_dst, fwd_regs_wr, stall_req
  );

endinterface

// File: rtl/mem2_stage_hs_load_align_ext.sv
// load_align_ext: picks the addressed byte/half/word from bus data and extends it.
// rdata_i, offset_i (byte lane), load_type_i -> data_o. Purely combinational.
module load_align_ext
  import mem2_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  load_type_e        load_type_i,
  output logic [DATA_W-1:0] data_o
);

  logic [OFF_W-1:0] off_h;
  logic [OFF_W-1:0] off_w;
  logic [7:0]       b;
  logic [15:0]      h;
  logic [31:0]      w;

  // Halfword and word lanes ignore the low offset bits.
  assign off_h = offset_i & ~OFF_W'(1);
  assign off_w = offset_i & ~OFF_W'(3);

  assign b = rdata_i[{offset_i, 3'b000} +: 8];
  assign h = rdata_i[{off_h, 3'b000} +: 16];
  assign w = rdata_i[{off_w, 3'b000} +: 32];

  always_comb begin
    data_o = DATA_W'($signed(w));
    unique case (load_type_i)
      LB:      data_o = DATA_W'($signed(b));
      LBU:     data_o = DATA_W'(b);
      LH:      data_o = DATA_W'($signed(h));
      LHU:     data_o = DATA_W'(h);
      default: data_o = DATA_W'($signed(w));
    endcase
  end

endmodule

// File: rtl/mem2_stage_hs.sv
// mem2_stage_hs: MEM2 stage; one-entry valid/ready buffer with late load data.
// Ports: clk, resetn (async, active low), bus (mem2_stage_hs_if.slave); MEM2_ALIGN_CHECK_EN adds out_addr_err.
module mem2_stage_hs
  import mem2_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned PC_OFFSET = 8
) (
  input logic           clk,
  input logic           resetn,
  mem2_stage_hs_if.slave bus
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  mem2_state_e       state_q, state_d;
  logic              discard_q, discard_d;
  mem2_ctl_t         ctl_q, ctl_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] cap_result;
  logic [PC_W-1:0]   pc_link;
  logic              mis;
  logic              live;
  logic              data_arr;
  logic              out_valid;
  logic              retire;
  logic              in_ready;
  logic              accept;
  logic              unused_ctl;

  load_align_ext #(
    .DATA_W(DATA_W)
  ) u_ext (
    .rdata_i    (bus.dbus_rdata),
    .offset_i   (ctl_q.addr[OFF_W-1:0]),
    .load_type_i(ctl_q.load_type),
    .data_o     (ld_data)
  );

`ifdef MEM2_ALIGN_CHECK_EN
  logic addr_err_q;

  assign mis = (bus.in_wbsel == WB_LOAD)
             & is_misaligned(bus.in_load_type,
                             bus.in_alu_out[1:0]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_err_q <= 1'b0;
    end else if (accept) begin
      addr_err_q <= mis;
    end
  end

  assign bus.out_addr_err = addr_err_q;
`else
  assign mis = 1'b0;
`endif

  assign pc_link = bus.in_pc + PC_W'(PC_OFFSET);

  // Loads park the address here; a misaligned load keeps it as its result.
  always_comb begin
    cap_result = bus.in_alu_out;
    unique case (bus.in_wbsel)
      WB_PC8:  cap_result = DATA_W'(pc_link);
      WB_ALU:  cap_result = bus.in_alu_out;
      WB_OUTB: cap_result = bus.in_outb;
      default: cap_result = bus.in_alu_out;
    endcase
  end

  // A response owed to a flushed load is swallowed via discard_q.
  assign live      = (state_q != S_EMPTY);
  assign data_arr  = (state_q == S_WAIT_LOAD)
                   & bus.dbus_data_ok & ~discard_q;
  assign out_valid = (state_q == S_FULL) | data_arr;
  assign retire    = out_valid & bus.wb_ready;
  assign in_ready  = (state_q == S_EMPTY) | retire;
  assign accept    = bus.in_valid & in_ready & ~bus.flush;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    ctl_d     = ctl_q;
    result_d  = result_q;

    if (discard_q && bus.dbus_data_ok) begin
      discard_d = 1'b0;
    end

    if (bus.flush) begin
      state_d = S_EMPTY;
      // This load's response is still owed unless it arrives now.
      if ((state_q == S_WAIT_LOAD) && !data_arr) begin
        discard_d = 1'b1;
      end
    end else if (accept) begin
      state_d = ((bus.in_wbsel == WB_LOAD) && !mis)
              ? S_WAIT_LOAD : S_FULL;
      ctl_d.pc        = PC_W_MAX'(bus.in_pc);
      ctl_d.dst       = REG_AW_MAX'(bus.in_dst);
      ctl_d.regs_wr   = bus.in_regs_wr & ~mis;
      ctl_d.wbsel     = bus.in_wbsel;
      ctl_d.load_type = bus.in_load_type;
      ctl_d.addr      = OFF_W_MAX'(bus.in_alu_out[OFF_W-1:0]);
      result_d        = cap_result;
    end else if (retire) begin
      state_d = S_EMPTY;
    end else if (data_arr) begin
      state_d  = S_FULL;
      result_d = ld_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_EMPTY;
      discard_q <= 1'b0;
      ctl_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      ctl_q     <= ctl_d;
      result_q  <= result_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_result  = data_arr ? ld_data : result_q;
  assign bus.out_pc      = PC_W'(ctl_q.pc);
  assign bus.out_dst     = REG_AW'(ctl_q.dst);
  assign bus.out_regs_wr = ctl_q.regs_wr;
  assign bus.stall_req   = (state_q == S_WAIT_LOAD) & ~data_arr;

  assign bus.fwd_valid   = live;
  assign bus.fwd_data_ok = out_valid;
  assign bus.fwd_result  = bus.out_result;
  assign bus.fwd_dst     = live ? REG_AW'(ctl_q.dst) : '0;
  assign bus.fwd_regs_wr = live & ctl_q.regs_wr;

  // Bundle bits beyond this build's widths are never read.
  assign unused_ctl = ^ctl_q;

endmodule

// File: doc/mem2_stage_hs.md
Name: mem2_stage_hs

Overview:
- Parametrised second memory-access stage (MEM2) of the in-order pipeline, between MEM and WB.
- Holds one instruction and selects its write-back result: PC+PC_OFFSET, ALU result, operand B, or load data.
- Load data from the data bus is aligned and sign/zero-extended; a stage-internal buffer holds it if WB stalls.
- Uses a valid/ready handshake with late-data waiting instead of a bare write-enabled register, and drives forwarding outputs with a data-ready qualifier.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- PC_W, 32, program counter width.
- REG_AW, 5, register-file address width.
- PC_OFFSET, 8, added to PC for the link-write result (wbsel 0).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  kill stage contents (exception/redirect).
- in_valid  in  1  MEM presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  PC_W  instruction PC.
- in_alu_out  in  DATA_W  ALU result / load address.
- in_outb  in  DATA_W  operand B (MTC0/MTHI/MTLO path).
- in_wbsel  in  2  result select: 0 PC+OFF, 1 ALU, 2 OutB, 3 load.
- in_dst  in  REG_AW  destination register.
- in_regs_wr  in  1  register write enable.
- in_load_type  in  3  load_type_e.
- dbus_rdata  in  DATA_W  data-bus read data.
- dbus_data_ok  in  1  one-cycle pulse; dbus_rdata valid.
- out_valid  out  1  result valid to WB.
- wb_ready  in  1  WB accepts.
- out_pc  out  PC_W; out_result  out  DATA_W; out_dst  out  REG_AW; out_regs_wr  out  1.
- fwd_valid  out  1  stage holds a live instruction.
- fwd_data_ok  out  1  fwd_result usable this cycle.
- fwd_result  out  DATA_W; fwd_dst  out  REG_AW; fwd_regs_wr  out  1.
- stall_req  out  1  load waiting for data.

Behaviour:
- **Reset (asynchronous, resetn=0):** state=EMPTY, discard=0, all registered fields 0, out_valid=0, fwd_valid=0, stall_req=0.
- **States:**
  - EMPTY: no instruction held.
  - WAIT_LOAD: load held, data not yet arrived.
  - FULL: result complete.
- **Acceptance:** in_ready = (state==EMPTY) | (out_valid & wb_ready). Accept when in_valid & in_ready & !flush; the next state is WAIT_LOAD if in_wbsel==3, otherwise FULL.
- **Non-load result:** computed at capture and registered. It appears one cycle after acceptance.
- **WAIT_LOAD, no data yet:** data_ok=0 keeps the state; out_valid=0 and stall_req=1.
- **WAIT_LOAD, data arrives (data_ok=1 and discard=0):**
  - The extracted data is presented combinationally: out_valid=1, out_result=extracted value, fwd_data_ok=1.
  - If wb_ready=1, the instruction retires that cycle.
  - If wb_ready=0, the extracted value is latched into the hold register and the state moves to FULL.
- **FULL:** the instruction retires when wb_ready=1.
- **Retire:** the next state is EMPTY, or the new instruction's state if one is accepted in the same cycle.
- **Flush:**
  - Any state goes to EMPTY next cycle; flush blocks acceptance in that cycle.
  - Flush in WAIT_LOAD without data_ok in the same cycle sets discard=1, because the bus response is still outstanding.
  - While discard=1, the next data_ok clears discard and is ignored.
  - Loads accepted while discard=1 wait for a later data_ok.
  - Flush and data_ok in the same cycle: the data is consumed, discard stays 0.
- **Load extraction:**
  - Byte offset is in_alu_out[log2(DATA_W/8)-1:0], little-endian.
  - LB/LBU: byte at offset; LH/LHU: halfword at offset&~1; LW: word at offset&~3.
  - Signed types sign-extend to DATA_W, unsigned types zero-extend; LW sign-extends when DATA_W=64.
- **Forwarding:**
  - fwd_valid = state!=EMPTY.
  - fwd_data_ok = FULL, or WAIT_LOAD with accepted data_ok.
  - fwd_result = out_result.
  - fwd_dst and fwd_regs_wr are the registered fields, gated to 0 when state==EMPTY.
- **PC+PC_OFFSET:** width PC_W, wraps modulo 2^PC_W, zero-extended or truncated to DATA_W.

Optional Feature:
- Macro: MEM2_ALIGN_CHECK_EN.
- **When defined:**
  - Adds an output out_addr_err (1 bit), registered with the instruction.
  - out_addr_err is set for LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - Such a load skips WAIT_LOAD, goes to FULL with out_result=in_alu_out (bad address), and out_regs_wr=0.
- **When undefined:** no port; misaligned addresses are extracted using the truncated offset.

Decomposition:
- Package mem2_pkg holds:
  - load_type_e: LW=0, LB=1, LBU=2, LH=3, LHU=4.
  - wbsel_e: WB_PC8, WB_ALU, WB_OUTB, WB_LOAD.
  - mem2_state_e.
  - A struct grouping the pc/dst/regs_wr/wbsel/load_type/addr fields.
- One sub-module: load_align_ext, purely combinational (rdata, offset, load_type -> extended data).

Test Plan:
- ALU op: in_wbsel=1, in_alu_out=0x1234_5678, wb_ready=1 -> next cycle out_valid=1, out_result=0x12345678, fwd_data_ok=1.
- LB at addr 0x...03, rdata=0x80AA_BBCC, data_ok two cycles after accept:
  - stall_req=1 for 2 cycles.
  - Then out_result=0xFFFF_FF80 in the same cycle as data_ok.
  - LBU of the same -> 0x0000_0080.
- Load with wb_ready=0 at data_ok: result held in FULL for 3 cycles unchanged; dbus_rdata toggled meanwhile has no effect; retire on wb_ready.
- Flush in WAIT_LOAD:
  - Next cycle EMPTY, discard=1.
  - A new LW accepted; the first data_ok (0xDEAD) is ignored.
  - The second data_ok (0xBEEF) yields out_result=0xBEEF.
- Back-to-back: JAL at pc=0x8000_0000 (wbsel=0) retires while the next instr is accepted -> out_result=0x8000_0008, no bubble, in_ready=1 every cycle.
- Reset asserted mid-WAIT_LOAD (asynchronous) -> outputs 0 immediately, discard=0; a following stray data_ok is ignored (state EMPTY).
